// File: rtl/booth_mul_pkg.sv
// rtl/booth_mul_pkg.sv - shared types and defaults for the sequential Booth multiplier
package booth_mul_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SEL_NOP = 2'b00,
        SEL_ADD = 2'b01,
        SEL_SUB = 2'b10
    } sel_t;

    // Radix-2 recoding of the multiplier bit pair {Q[0], q_1}
    function automatic sel_t booth_sel(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return SEL_ADD;
            2'b10:   return SEL_SUB;
            default: return SEL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul5_if.sv
// rtl/booth_mul5_if.sv - operand and product handshakes of the Booth multiplier
interface booth_mul5_if
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     P;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P
    );

endinterface

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - (WIDTH+1)-bit add/sub used by each Booth step
module booth_addsub
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] m_ext,
    input  sel_t           sel,
    output logic [WIDTH:0] sum
);

    // The extra bit keeps -(-2^(WIDTH-1)) representable; wrap is silent.
    always_comb begin
        sum = acc;
        case (sel)
            SEL_ADD: sum = acc + m_ext;
            SEL_SUB: sum = acc - m_ext;
            default: sum = acc;
        endcase
    end

endmodule

// File: rtl/booth_mul5.sv
// rtl/booth_mul5.sv - sequential radix-2 Booth multiplier, one step per clock
module booth_mul5
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    booth_mul5_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    cnt;

    sel_t             sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;

    assign sel = booth_sel(q[0], q_1);

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .acc   (acc),
        .m_ext ({m[WIDTH-1], m}),
        .sel   (sel),
        .sum   (sum)
    );

    // Arithmetic shift right of {sum, Q, q_1}
    assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            bus.P <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        m     <= bus.A;
                        q     <= bus.B;
                        q_1   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    q   <= q_next;
                    q_1 <= q[0];
                    cnt <= cnt + CW'(1);
                    // Last step: capture the product straight from the shifter
                    if (cnt == CW'(WIDTH - 1)) begin
                        bus.P <= {acc_next[WIDTH-1:0], q_next};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
